// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control path: state encodings,
// opcodes, ALU-op classes, extender selects and ALU control codes.
package multicycle_controller_pkg;

    // Encodings are fixed so the debug state output matches the core documentation.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // Extender select depends only on the opcode, independent of state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OpStore: sel = ImmS;
            OpBeq:   sel = ImmB;
            OpJal:   sel = ImmJ;
            default: sel = ImmI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the controller and the multicycle datapath.
interface multicycle_controller_if #(
    parameter int unsigned STATE_W = 4
);
    import multicycle_controller_pkg::*;

    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               mem_ready;
    logic [1:0]         immsrc;
    logic [1:0]         alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         resultsrc;
    logic               adrsrc;
    logic [2:0]         alucontrol;
    logic               irwrite;
    logic               pcwrite;
    logic               regwrite;
    logic               memwrite;
    logic               illegal;
    logic [STATE_W-1:0] state;

    // Controller side.
    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
        output irwrite, pcwrite, regwrite, memwrite, illegal, state
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
        input  irwrite, pcwrite, regwrite, memwrite, illegal, state
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU-op class and instruction fields to an ALU operation.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Only R-type sets both op[5] and funct7[5]; addi must stay an add.
    always_comb begin
        alucontrol = AluAdd;
        case (aluop)
            AluOpSub: alucontrol = AluSub;
            AluOpFunct: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? AluSub : AluAdd;
                    3'b010:  alucontrol = AluSlt;
                    3'b110:  alucontrol = AluOr;
                    3'b111:  alucontrol = AluAnd;
                    default: alucontrol = AluAdd;
                endcase
            end
            default: alucontrol = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences the shared ALU, extender, IR, PC and
// the unified memory port, stalling FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned STATE_W       = 4,
    parameter bit          USE_MEM_READY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    logic       ready;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       illegal_raw;

    assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

    // State register; reset returns to FETCH immediately, even mid-instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode; unlisted selects default to 0.
    always_comb begin
        state_d       = StFetch;
        bus.alusrca   = 2'b00;
        bus.alusrcb   = 2'b00;
        bus.resultsrc = 2'b00;
        bus.adrsrc    = 1'b0;
        aluop         = AluOpAdd;
        irwrite_raw   = 1'b0;
        regwrite_raw  = 1'b0;
        memwrite_raw  = 1'b0;
        illegal_raw   = 1'b0;
        pcupdate      = 1'b0;
        branch        = 1'b0;
        case (state_q)
            StFetch: begin
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b10;
                if (ready) begin
                    irwrite_raw = 1'b1;
                    pcupdate    = 1'b1;
                    state_d     = StDecode;
                end else begin
                    state_d = StFetch;
                end
            end
            StDecode: begin
                // Branch/jump target is computed here and parked in ALUOut.
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBeq:           state_d = StBeq;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                state_d     = bus.op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                bus.adrsrc = 1'b1;
                state_d    = ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                bus.resultsrc = 2'b01;
                regwrite_raw  = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                // Strobe held until the memory accepts the write.
                bus.adrsrc   = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = ready ? StFetch : StMemWrite;
            end
            StExecR: begin
                bus.alusrca = 2'b10;
                aluop       = AluOpFunct;
                state_d     = StAluWb;
            end
            StExecI: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                aluop       = AluOpFunct;
                state_d     = StAluWb;
            end
            StAluWb: begin
                regwrite_raw = 1'b1;
                state_d      = StFetch;
            end
            StJal: begin
                // ALU computes the link address (OldPC + 4) while the PC takes the target.
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                pcupdate    = 1'b1;
                state_d     = StAluWb;
            end
            StBeq: begin
                bus.alusrca = 2'b10;
                aluop       = AluOpSub;
                branch      = 1'b1;
                state_d     = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Write strobes are suppressed while reset is asserted.
    always_comb begin
        bus.irwrite  = irwrite_raw & ~reset;
        bus.regwrite = regwrite_raw & ~reset;
        bus.memwrite = memwrite_raw & ~reset;
        bus.illegal  = illegal_raw & ~reset;
        bus.pcwrite  = (pcupdate | (branch & bus.zero)) & ~reset;
        bus.immsrc   = imm_sel(bus.op);
        bus.state    = STATE_W'(state_q);
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (bus.alucontrol)
    );

endmodule
